seq_shift_unit: RTL and testbench
=================================

# seq_shift_unit

Parametrised multi-cycle shift unit with a start/busy/done handshake.
- Supports logical left/right shift with a selectable fill bit, arithmetic right shift, and rotate left.
- Shifts one bit position per clock for a programmable number of positions.
- Successor to the fixed 23-bit one-position fill shifter; serves the mantissa datapath of the multiply/divide and floating-point normalise sequencers.

## Interface

Parameters:
- WIDTH, 23, data width in bits (≥2)
- AMT_W, 5, width of the shift-amount field; amount range 0..2^AMT_W-1

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when busy=0
- mode  input  2  00 logical left, 01 logical right, 10 arithmetic right, 11 rotate left
- fill  input  1  bit shifted in for modes 00/01; ignored for 10/11
- amount  input  AMT_W  number of one-bit shift steps
- din  input  WIDTH  operand
- busy  output  1  high while in SHIFT
- done  output  1  one-cycle pulse; dout is valid
- dout  output  WIDTH  result register

## Operation

- States: IDLE, SHIFT, DONE. Reset → IDLE.
- **IDLE / DONE:** start=1 latches din into the data register and latches mode, fill and amount into the internal counter.
  - amount=0 → next state DONE.
  - Otherwise → next state SHIFT.
  - start=0 → next state IDLE.
- **SHIFT:** each clock performs one step and decrements the counter. The step taken on counter=1 is the last one; next state is DONE.
- **DONE:** lasts exactly one cycle with done=1. A start sampled in DONE is accepted as in IDLE, so back-to-back operations incur no gap.
- Step per mode, with r the data register:
  - 00: r ← {r[WIDTH-2:0], fill}
  - 01: r ← {fill, r[WIDTH-1:1]}
  - 10: r ← {r[WIDTH-1], r[WIDTH-1:1]}
  - 11: r ← {r[WIDTH-2:0], r[WIDTH-1]}
- **amount ≥ WIDTH:** not clamped; all steps are executed.
  - Modes 00/01 give all-fill.
  - Mode 10 gives all-sign.
  - Mode 11 gives rotation by amount mod WIDTH.
- **Input sampling:** mode, fill, amount and din are sampled only at the accepting edge. Later changes do not affect the operation in flight.
- **start while busy=1:** ignored. No queueing, no error flag.
- **dout:** drives r directly. It holds its value after DONE until the next accepted start, which reloads it with din.

## Timing

- **Reset values:** state=IDLE, busy=0, done=0, dout=0, counter=0.
- **Latency:** start accepted at edge E with amount=N:
  - N≥1: busy=1 for the N cycles after E; done=1 in cycle N+1 after E.
  - N=0: done=1 in the cycle after E and dout=din.
- busy and done are never high in the same cycle.
- **Throughput:** one operation per N+1 cycles, with start asserted during DONE.
- **rst:**
  - Has priority over start.
  - Asserted mid-SHIFT it aborts the operation: the next cycle shows busy=0, done=0, dout=0, and no done pulse is generated.
- All outputs are registered. No combinational path from inputs to outputs.

## Test plan

- WIDTH=23, mode=00, fill=1, din=23'h000001, amount=3 → busy high 3 cycles, then done pulse with dout=23'h00000F.
- mode=10, din=23'h400000, amount=4 → dout=23'h7C0000. Repeat with mode=01, fill=0 → dout=23'h040000.
- mode=11, din=23'h400001, amount=1 → dout=23'h000003. Repeat with amount=24 → dout=23'h000003, done 25 cycles after start.
- amount=0, din=23'h12345 → done in the next cycle with dout=23'h12345, busy never asserted.
- start re-pulsed mid-SHIFT with different din → result unaffected. start held during DONE → second operation begins with no idle cycle.
- rst asserted at the second SHIFT cycle of an amount=10 operation → next cycle busy=0, dout=0, no done pulse. A fresh start afterwards completes normally.

Source files
------------

// File: rtl/seq_shift_unit_if.sv
// ============================================================================
// seq_shift_unit_if : start/busy/done request bus of the multi-cycle shifter
// Revision: 1.0
// ============================================================================
`default_nettype none

interface seq_shift_unit_if #(
  parameter int WIDTH = 23,
  parameter int AMT_W = 5
);
  logic             start;
  logic [1:0]       mode;
  logic             fill;
  logic [AMT_W-1:0] amount;
  logic [WIDTH-1:0] din;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] dout;

  modport master (
    output start, mode, fill, amount, din,
    input  busy, done, dout
  );

  modport slave (
    input  start, mode, fill, amount, din,
    output busy, done, dout
  );
endinterface

`default_nettype wire

// File: rtl/seq_shift_unit.sv
// ============================================================================
// seq_shift_unit : one-bit-per-clock shift/rotate unit with start/busy/done
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_shift_unit #(
  parameter int WIDTH = 23,
  parameter int AMT_W = 5
) (
  input  wire               clk,
  input  wire               rst,
  seq_shift_unit_if.slave   bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  localparam logic [1:0] M_LSL = 2'b00;
  localparam logic [1:0] M_LSR = 2'b01;
  localparam logic [1:0] M_ASR = 2'b10;

  logic [1:0]       state_q,  state_d;
  logic [AMT_W-1:0] cnt_q,    cnt_d;
  logic [1:0]       mode_q,   mode_d;
  logic             fill_q,   fill_d;
  logic [WIDTH-1:0] data_q,   data_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [WIDTH-1:0] step_val;

  always_comb begin
    case (mode_q)
      M_LSL:   step_val = {data_q[WIDTH-2:0], fill_q};
      M_LSR:   step_val = {fill_q, data_q[WIDTH-1:1]};
      M_ASR:   step_val = {data_q[WIDTH-1], data_q[WIDTH-1:1]};
      default: step_val = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    fill_d  = fill_q;
    data_d  = data_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        // DONE accepts a new start exactly like IDLE so operations chain gap-free
        if (bus.start) begin
          data_d  = bus.din;
          mode_d  = bus.mode;
          fill_d  = bus.fill;
          cnt_d   = bus.amount;
          state_d = (bus.amount == '0) ? S_DONE : S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        data_d = step_val;
        cnt_d  = cnt_q - AMT_W'(1);
        if (cnt_q == AMT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_SHIFT);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
      fill_q  <= 1'b0;
      data_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      fill_q  <= fill_d;
      data_q  <= data_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dout = data_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_shift_unit.sv
// ============================================================================
// tb_seq_shift_unit : directed + randomized check of seq_shift_unit
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seq_shift_unit;

  localparam int W  = 23;
  localparam int AW = 5;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  seq_shift_unit_if #(.WIDTH(W), .AMT_W(AW)) bus ();

  seq_shift_unit #(.WIDTH(W), .AMT_W(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Whole-operation result from the arithmetic meaning of each mode
  function automatic logic [W-1:0] model(input logic [1:0] m, input logic f,
                                         input int n, input logic [W-1:0] d);
    logic [63:0] mask, x, top;
    int k;
    mask = (64'd1 << W) - 64'd1;
    x    = {41'd0, d};
    case (m)
      2'b00: begin
        if (n >= W) return {W{f}};
        x = ((x << n) | (f ? ((64'd1 << n) - 64'd1) : 64'd0)) & mask;
      end
      2'b01, 2'b10: begin
        logic b;
        b = (m == 2'b10) ? d[W-1] : f;
        if (n >= W) return {W{b}};
        top = mask ^ (mask >> n);
        x = (x >> n) | (b ? top : 64'd0);
      end
      default: begin
        k = n % W;
        x = ((x << k) | (x >> (W - k))) & mask;
      end
    endcase
    return x[W-1:0];
  endfunction

  // Entered at a negedge; returns at the negedge of the done cycle with inputs
  // left dirty so the caller can either chain a start or drop it.
  task automatic do_op(input logic [1:0] m, input logic f, input int n,
                       input logic [W-1:0] d, input logic [W-1:0] exp);
    bus.start  = 1'b1;
    bus.mode   = m;
    bus.fill   = f;
    bus.amount = AW'(n);
    bus.din    = d;
    for (int k = 1; k <= n + 1; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k <= n) begin
        check("busy_in_shift", {31'd0, bus.busy}, 32'd1);
        check("done_in_shift", {31'd0, bus.done}, 32'd0);
        bus.start  = 1'($urandom);
        bus.mode   = 2'($urandom);
        bus.fill   = 1'($urandom);
        bus.amount = AW'($urandom);
        bus.din    = W'($urandom);
      end else begin
        check("done_pulse", {31'd0, bus.done}, 32'd1);
        check("busy_at_done", {31'd0, bus.busy}, 32'd0);
        check("dout", {9'd0, bus.dout}, {9'd0, exp});
      end
    end
  endtask

  task automatic idle(input int cycles, input logic [W-1:0] exp);
    bus.start = 1'b0;
    bus.din   = W'($urandom);
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("idle_busy", {31'd0, bus.busy}, 32'd0);
      check("idle_done", {31'd0, bus.done}, 32'd0);
      check("idle_hold", {9'd0, bus.dout}, {9'd0, exp});
    end
  endtask

  initial begin
    logic [1:0]   m;
    logic         f;
    int           n;
    logic [W-1:0] d;
    logic [W-1:0] e;

    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.start = 1'b0; bus.mode = 2'b00; bus.fill = 1'b0;
    bus.amount = '0;  bus.din = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_dout", {9'd0, bus.dout}, 32'd0);
    rst = 1'b0;
    idle(1, '0);

    do_op(2'b00, 1'b1, 3,  23'h000001, 23'h00000F); idle(1, 23'h00000F);
    do_op(2'b10, 1'b0, 4,  23'h400000, 23'h7C0000); idle(1, 23'h7C0000);
    do_op(2'b01, 1'b0, 4,  23'h400000, 23'h040000); idle(1, 23'h040000);
    do_op(2'b11, 1'b0, 1,  23'h400001, 23'h000003); idle(1, 23'h000003);
    do_op(2'b11, 1'b0, 24, 23'h400001, 23'h000003); idle(1, 23'h000003);
    do_op(2'b00, 1'b1, 0,  23'h012345, 23'h012345); idle(2, 23'h012345);
    do_op(2'b00, 1'b0, 31, 23'h7FFFFF, 23'h000000);
    do_op(2'b01, 1'b1, 25, 23'h000000, 23'h7FFFFF); idle(1, 23'h7FFFFF);

    // Reset at the second SHIFT cycle of an amount=10 operation
    bus.start = 1'b1; bus.mode = 2'b00; bus.fill = 1'b1;
    bus.amount = AW'(10); bus.din = 23'h0000AB;
    @(posedge clk); @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk); @(negedge clk);
    check("pre_rst_busy", {31'd0, bus.busy}, 32'd1);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("abort_busy", {31'd0, bus.busy}, 32'd0);
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_dout", {9'd0, bus.dout}, 32'd0);
    idle(12, '0);
    do_op(2'b10, 1'b0, 2, 23'h500000, 23'h740000); idle(1, 23'h740000);

    // Random operations, sometimes chained straight out of DONE
    for (int i = 0; i < 200; i++) begin
      m = 2'($urandom);
      f = 1'($urandom);
      n = ($urandom_range(0, 3) == 0) ? $urandom_range(W - 1, 31) : $urandom_range(0, 8);
      d = W'($urandom);
      e = model(m, f, n, d);
      do_op(m, f, n, d, e);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3), e);
    end
    idle(1, e);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
